// File: rtl/fetch_unit.sv
// Instruction fetch stage: streams words from a combinational instruction memory
// into a one-entry valid/ready output register, with redirect and halt handling.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] HLT_WORD = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       redirect_valid,
    input  logic [7:0] redirect_addr,
    output logic [7:0] instr,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       halted
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_instr;
    logic [7:0] r_instr_pc;
    logic       r_valid;

    logic       w_slot_free;
    logic       w_is_halt;

    // The output slot can take a new word when empty or being drained this edge.
    assign w_slot_free = !r_valid || instr_ready;
    assign w_is_halt   = (imem_data == HLT_WORD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_instr    <= 8'h00;
            r_instr_pc <= 8'h00;
            r_valid    <= 1'b0;
        end else if (redirect_valid) begin
            r_state <= S_RUN;
            r_pc    <= redirect_addr;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_slot_free) begin
                        r_instr    <= imem_data;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_pc       <= r_pc + 8'd1;
                        if (w_is_halt) begin
                            r_state <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    // The halt word itself still has to drain to decode.
                    if (r_valid && instr_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the corner cases, then random
// traffic checked against a queue-based model of the fetch rules.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       halted;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .halted         (halted)
    );

    typedef struct {
        logic       rst;
        logic       rv;
        logic [7:0] ra;
        logic       rdy;
        logic [7:0] e_addr;
        logic [7:0] e_instr;
        logic [7:0] e_pc;
        logic       e_valid;
        logic       e_halted;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [7:0] word;
        logic [7:0] pc;
    } slot_t;

    task automatic add(input logic r, input logic rv, input logic [7:0] ra, input logic rdy,
                       input logic [7:0] ea, input logic [7:0] ei, input logic [7:0] ep,
                       input logic ev, input logic eh);
        vec_t v;
        v = '{r, rv, ra, rdy, ea, ei, ep, ev, eh};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %02h expected %02h", name, step, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int step, input logic [7:0] ea,
                             input logic ev, input logic eh, input logic [7:0] ei,
                             input logic [7:0] ep);
        check({tag, "_imem_addr"}, step, imem_addr, ea);
        check({tag, "_valid"}, step, {7'd0, instr_valid}, {7'd0, ev});
        check({tag, "_halted"}, step, {7'd0, halted}, {7'd0, eh});
        if (ev) begin
            check({tag, "_instr"}, step, instr, ei);
            check({tag, "_instr_pc"}, step, instr_pc, ep);
        end
        $display("%s step %0d: addr=%02h valid=%0d halted=%0d instr=%02h pc=%02h",
                 tag, step, imem_addr, instr_valid, halted, instr, instr_pc);
    endtask

    // Reference model state
    logic [7:0] m_fetch;
    logic       m_halted;
    slot_t      m_slot[$];

    task automatic model_edge(input logic r, input logic rv, input logic [7:0] ra,
                              input logic rdy);
        slot_t s;
        if (r) begin
            m_fetch  = 8'h00;
            m_halted = 1'b0;
            m_slot.delete();
        end else if (rv) begin
            m_fetch  = ra;
            m_halted = 1'b0;
            m_slot.delete();
        end else begin
            if (m_slot.size() != 0 && rdy) void'(m_slot.pop_front());
            if (!m_halted && m_slot.size() == 0) begin
                s.word = mem[m_fetch];
                s.pc   = m_fetch;
                m_slot.push_back(s);
                if (s.word == 8'h00) m_halted = 1'b1;
                m_fetch = m_fetch + 8'd1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr = 8'h00;
        instr_ready = 1'b0;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) | 8'h80;
        mem[0] = 8'hA2; mem[1] = 8'hAB; mem[2] = 8'h08; mem[3] = 8'hE2;
        mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h00; mem[7] = 8'h33;
        mem[8'hFF] = 8'h20;

        //  rst rv  ra     rdy   addr   instr  pc     v  h
        add(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0);  // reset state
        add(0, 0, 8'h00, 1, 8'h01, 8'hA2, 8'h00, 1, 0);  // first fetch after reset
        add(0, 0, 8'h00, 1, 8'h02, 8'hAB, 8'h01, 1, 0);
        add(0, 0, 8'h00, 0, 8'h02, 8'hAB, 8'h01, 1, 0);  // stall x3
        add(0, 0, 8'h00, 0, 8'h02, 8'hAB, 8'h01, 1, 0);
        add(0, 0, 8'h00, 0, 8'h02, 8'hAB, 8'h01, 1, 0);
        add(0, 0, 8'h00, 1, 8'h03, 8'h08, 8'h02, 1, 0);
        add(0, 0, 8'h00, 1, 8'h04, 8'hE2, 8'h03, 1, 0);
        add(0, 1, 8'h02, 0, 8'h02, 8'h00, 8'h00, 0, 0);  // redirect while stalled
        add(0, 0, 8'h00, 0, 8'h03, 8'h08, 8'h02, 1, 0);
        add(0, 0, 8'h00, 1, 8'h04, 8'hE2, 8'h03, 1, 0);
        add(0, 0, 8'h00, 1, 8'h05, 8'h11, 8'h04, 1, 0);
        add(0, 0, 8'h00, 1, 8'h06, 8'h22, 8'h05, 1, 0);
        add(0, 0, 8'h00, 0, 8'h06, 8'h22, 8'h05, 1, 0);
        add(0, 0, 8'h00, 1, 8'h07, 8'h00, 8'h06, 1, 1);  // halt word loaded
        add(0, 0, 8'h00, 0, 8'h07, 8'h00, 8'h06, 1, 1);
        add(0, 0, 8'h00, 1, 8'h07, 8'h00, 8'h00, 0, 1);  // halt word drained
        add(0, 0, 8'h00, 1, 8'h07, 8'h00, 8'h00, 0, 1);
        add(0, 1, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0, 0);  // resume via redirect
        add(0, 0, 8'h00, 1, 8'h01, 8'hA2, 8'h00, 1, 0);
        add(0, 1, 8'hFF, 1, 8'hFF, 8'h00, 8'h00, 0, 0);  // wrap
        add(0, 0, 8'h00, 1, 8'h00, 8'h20, 8'hFF, 1, 0);
        add(0, 0, 8'h00, 1, 8'h01, 8'hA2, 8'h00, 1, 0);
        add(0, 1, 8'h05, 1, 8'h05, 8'h00, 8'h00, 0, 0);  // back-to-back redirects
        add(0, 1, 8'h03, 1, 8'h03, 8'h00, 8'h00, 0, 0);
        add(0, 0, 8'h00, 1, 8'h04, 8'hE2, 8'h03, 1, 0);
        add(0, 1, 8'h06, 1, 8'h06, 8'h00, 8'h00, 0, 0);
        add(0, 0, 8'h00, 0, 8'h07, 8'h00, 8'h06, 1, 1);
        add(1, 1, 8'h05, 1, 8'h00, 8'h00, 8'h00, 0, 0);  // reset beats redirect in HALT
        add(0, 0, 8'h00, 1, 8'h01, 8'hA2, 8'h00, 1, 0);
        add(0, 1, 8'h02, 1, 8'h02, 8'h00, 8'h00, 0, 0);  // redirect discards despite ready
        add(0, 0, 8'h00, 1, 8'h03, 8'h08, 8'h02, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst            = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_addr  = vecs[i].ra;
            instr_ready    = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_all("vec", i, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_halted,
                      vecs[i].e_instr, vecs[i].e_pc);
        end

        // Random traffic; memory contains occasional halt words.
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        m_fetch  = 8'h00;
        m_halted = 1'b0;
        m_slot.delete();
        for (int i = 0; i < 600; i++) begin
            rst            = (i == 0) || ($urandom_range(0, 49) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_addr  = 8'($urandom_range(0, 255));
            instr_ready    = ($urandom_range(0, 9) < 6);
            model_edge(rst, redirect_valid, redirect_addr, instr_ready);
            @(posedge clk);
            #1;
            check_all("rnd", i, m_fetch, m_slot.size() != 0, m_halted,
                      (m_slot.size() != 0) ? m_slot[0].word : 8'h00,
                      (m_slot.size() != 0) ? m_slot[0].pc : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter HLT_WORD, default 8'h00, meaning the instruction encoding treated as halt.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_addr  output  8  address to the combinational instruction memory; always equals the PC register.
REQ-006 SHALL have port imem_data  input  8  instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  execute-stage request to change the PC (taken JZ).
REQ-008 SHALL have port redirect_addr  input  8  target PC; sampled only when redirect_valid=1.
REQ-009 SHALL have port instr  output  8  registered instruction offered to decode.
REQ-010 SHALL have port instr_pc  output  8  address from which instr was fetched.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-012 SHALL have port instr_ready  input  1  decode accepts instr this cycle.
REQ-013 SHALL have port halted  output  1  high while in the HALT state.

Function
REQ-014 SHALL implement a two-state FSM: RUN (fetching) and HALT (PC frozen, no new fetches).
REQ-015 SHALL define handshake: the instruction transfers on a rising edge where instr_valid=1 and instr_ready=1.
REQ-016 SHALL in RUN, when instr_valid=0 or a transfer occurs (and no redirect), load instr<=imem_data, instr_pc<=PC, instr_valid<=1, PC<=PC+1.
REQ-017 SHALL wrap PC modulo 256 (8'hFF increments to 8'h00) with no flag or stall.
REQ-018 SHALL in RUN, when instr_valid=1 and instr_ready=0, hold PC, instr, instr_pc and instr_valid unchanged (stall; no instruction lost or duplicated).
REQ-019 SHALL, when a word equal to HLT_WORD is loaded per REQ-016, deliver it as a normal valid instruction, leave PC at halt address+1, and move to HALT on that same edge.
REQ-020 SHALL in HALT perform no loads; instr_valid clears after the halt word transfers and stays 0 until a redirect or reset.
REQ-021 SHALL give redirect_valid=1 priority over all other behaviour (in RUN or HALT): PC<=redirect_addr, instr_valid<=0, state<=RUN; any instruction held is discarded, whether or not instr_ready=1 that cycle.
REQ-022 SHALL give redirect latency: redirect on edge N -> imem_addr=redirect_addr after edge N -> instr=mem[redirect_addr] with instr_valid=1 after edge N+1 (exactly one bubble cycle).
REQ-023 SHALL treat back-to-back redirects on consecutive edges so that only the last target is fetched; no intermediate instruction becomes valid.
REQ-024 SHALL sustain one instruction per cycle when instr_ready is held at 1 and no redirect or halt occurs.
REQ-025 SHALL drive halted combinationally from the FSM state (1 iff HALT).

Reset
REQ-026 SHALL on rst=1 at a rising edge set PC=RESET_PC, instr=8'h00, instr_pc=8'h00, instr_valid=0, state=RUN (halted=0); rst overrides redirect_valid and the handshake.
REQ-027 SHALL, when rst asserts mid-stall or mid-HALT, discard the held instruction and begin fetching from RESET_PC on the first edge with rst=0.
REQ-028 SHALL have the first edge after rst deasserts load mem[RESET_PC] with instr_valid=1.

Verification
REQ-029 Streaming: mem[0..2]=A2,AB,08, instr_ready=1 -> after reset release, instr=A2/AB/08 with instr_pc=0/1/2 on consecutive cycles, instr_valid=1 throughout.
REQ-030 Stall: instr_ready=0 for 3 cycles while instr=AB, instr_pc=1 -> instr, instr_pc and imem_addr=2 held; on ready=1 the next instr is 08 at pc 2, no skip or duplicate.
REQ-031 Redirect: redirect_valid=1, redirect_addr=02 while instr=E2 valid, instr_ready=0 -> next cycle instr_valid=0, imem_addr=02; following cycle instr=08, instr_pc=02, valid=1.
REQ-032 Halt and resume: mem[6]=00 -> instr=00, instr_pc=06 valid, halted=1, imem_addr=07 frozen; after transfer instr_valid=0 indefinitely; redirect to 00 -> halted=0, instr=A2 one cycle later.
REQ-033 Wrap: redirect to FF, mem[FF]=20, mem[00]=A2 -> instr_pc=FF then 00 on consecutive transfers.
REQ-034 Reset priority: rst=1 with redirect_valid=1, redirect_addr=05 in HALT -> after reset release halted=0, first instr=mem[00] with instr_pc=00.
